// File: rtl/datapath_pipe.sv
// Two-stage datapath: decode register, then execute and writeback
// against a parametrised register file, stalling one cycle for LOAD.
module datapath_pipe #(
    parameter int WIDTH = 16,
    parameter int REGS  = 16,
    parameter int IMMW  = 8,
    localparam int AW   = $clog2(REGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [AW-1:0]    rdest,
    input  logic [AW-1:0]    rsrc,
    input  logic [IMMW-1:0]  imm,
    input  logic             use_imm,
    input  logic             imm_signed,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic             mem_we,
    input  logic [WIDTH-1:0] mem_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             C,
    output logic             L,
    output logic             F,
    output logic             Z,
    output logic             N
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_CMP   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_MOV   = 4'd6;
    localparam logic [3:0] OP_LSH   = 4'd7;
    localparam logic [3:0] OP_LOAD  = 4'd8;
    localparam logic [3:0] OP_STORE = 4'd9;

    localparam logic [WIDTH-1:0] WLIM = WIDTH'(WIDTH);

    typedef enum logic {S_IDLE, S_LWAIT} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [AW-1:0]    rdest;
        logic [AW-1:0]    rsrc;
        logic [WIDTH-1:0] imm;
        logic             use_imm;
    } dec_t;

    dec_t             d;
    logic             d_valid;
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] rf [REGS];
    logic [WIDTH-1:0] ext;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] alu;
    logic [WIDTH-1:0] mag;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   dif;
    logic             fc, fl, ff, fz, fn;
    logic             wr_en;
    logic             flag_en;
    logic             accept;
    logic             is_load;

    assign ext = imm_signed ? {{(WIDTH-IMMW){imm[IMMW-1]}}, imm}
                            : {{(WIDTH-IMMW){1'b0}}, imm};
    assign accept = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_valid <= 1'b0;
            d       <= '0;
        end else begin
            d_valid <= accept;
            if (accept) begin
                d <= '{op: op, rdest: rdest, rsrc: rsrc,
                       imm: ext, use_imm: use_imm};
            end
        end
    end

    assign b         = rf[d.rdest];
    assign a         = d.use_imm ? d.imm : rf[d.rsrc];
    assign mem_adr   = rf[d.rsrc];
    assign mem_wdata = b;
    assign sum       = {1'b0, b} + {1'b0, a};
    assign dif       = {1'b0, b} - {1'b0, a};
    assign mag       = a[WIDTH-1] ? (~a + 1'b1) : a;

    always_comb begin
        alu     = '0;
        wr_en   = 1'b0;
        flag_en = 1'b0;
        fc      = 1'b0;
        fl      = 1'b0;
        ff      = 1'b0;
        fn      = 1'b0;
        unique case (d.op)
            OP_ADD: begin
                alu     = sum[WIDTH-1:0];
                wr_en   = 1'b1;
                flag_en = 1'b1;
                fc      = sum[WIDTH];
                ff      = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != b[WIDTH-1]);
            end
            OP_SUB, OP_CMP: begin
                alu     = dif[WIDTH-1:0];
                wr_en   = (d.op == OP_SUB);
                flag_en = 1'b1;
                fc      = dif[WIDTH];
                fl      = dif[WIDTH];
                fn      = $signed(b) < $signed(a);
                ff      = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (dif[WIDTH-1] != b[WIDTH-1]);
            end
            OP_AND: begin alu = b & a; wr_en = 1'b1; end
            OP_OR:  begin alu = b | a; wr_en = 1'b1; end
            OP_XOR: begin alu = b ^ a; wr_en = 1'b1; end
            OP_MOV: begin alu = a;     wr_en = 1'b1; end
            OP_LSH: begin
                wr_en = 1'b1;
                if (mag >= WLIM)     alu = '0;
                else if (a[WIDTH-1]) alu = b >> mag;
                else                 alu = b << mag;
            end
            OP_STORE: alu = b;
            default:  alu = '0;
        endcase
        fz = (alu == '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        mem_we     = 1'b0;
        is_load    = d_valid && (d.op == OP_LOAD);
        unique case (state)
            S_IDLE: begin
                in_ready = !is_load;
                mem_we   = d_valid && (d.op == OP_STORE);
                if (is_load) state_next = S_LWAIT;
            end
            S_LWAIT: state_next = S_IDLE;
        endcase
    end

    // The decode fields stay put through LWAIT, so d.rdest still names the load target.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid       <= 1'b0;
            result          <= '0;
            {C, L, F, Z, N} <= '0;
            for (int i = 0; i < REGS; i++) rf[i] <= '0;
        end else begin
            out_valid <= 1'b0;
            if (state == S_LWAIT) begin
                rf[d.rdest] <= mem_data;
                result      <= mem_data;
                out_valid   <= 1'b1;
            end else if (d_valid && !is_load) begin
                result    <= alu;
                out_valid <= 1'b1;
                if (wr_en)   rf[d.rdest] <= alu;
                if (flag_en) {C, L, F, Z, N} <= {fc, fl, ff, fz, fn};
            end
        end
    end

endmodule

// File: tb/tb_datapath_pipe.sv
// Bench for datapath_pipe: directed literal cases, then random stream
// checked every cycle against an architectural model.
module tb_datapath_pipe;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [3:0]  rdest;
    logic [3:0]  rsrc;
    logic [7:0]  imm;
    logic        use_imm;
    logic        imm_signed;
    logic [15:0] mem_adr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_data;
    logic        out_valid;
    logic [15:0] result;
    logic        C, L, F, Z, N;

    datapath_pipe dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid),
        .in_ready(in_ready), .op(op), .rdest(rdest), .rsrc(rsrc),
        .imm(imm), .use_imm(use_imm), .imm_signed(imm_signed),
        .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_data(mem_data), .out_valid(out_valid), .result(result),
        .C(C), .L(L), .F(F), .Z(Z), .N(N)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    function automatic void chk(string nm, logic [31:0] got,
                                logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", nm, got, exp, $time);
        end
    endfunction

    bit          mem_fix_en = 1'b0;
    logic [15:0] mem_fix    = 16'h0;

    always @(negedge clk) begin
        #1;
        mem_data = mem_fix_en ? mem_fix : 16'($urandom);
    end

    // Architectural model: instructions retire in accept order.
    typedef struct {
        int op;
        int rd;
        int rs;
        int imm;
        int due;
        bit ui;
    } ins_t;

    ins_t pend[$];
    int   mr[16];
    bit   mC, mL, mF, mZ, mN;
    bit   e_ov;
    int   e_res;
    int   n    = 0;
    int   lacc = -10;
    int   sacc = -10;
    bit   rdy;
    bit   will_acc = 1'b0;
    ins_t nw;

    function automatic int sgn(int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    function automatic void model_reset();
        pend.delete();
        for (int i = 0; i < 16; i++) mr[i] = 0;
        {mC, mL, mF, mZ, mN} = '0;
        e_ov  = 1'b0;
        e_res = 0;
        lacc  = -10;
        sacc  = -10;
    endfunction

    function automatic void exec(ins_t t, int md);
        int a, b, sa, sb, r;
        a  = t.ui ? t.imm : mr[t.rs];
        b  = mr[t.rd];
        sa = sgn(a);
        sb = sgn(b);
        r  = 0;
        case (t.op)
            0: begin
                r  = b + a;
                mC = r > 65535;
                mF = (sb + sa > 32767) || (sb + sa < -32768);
                mL = 0;
                mN = 0;
                r  = r & 65535;
                mZ = (r == 0);
            end
            1, 2: begin
                mC = b < a;
                mL = b < a;
                mN = sb < sa;
                mF = (sb - sa > 32767) || (sb - sa < -32768);
                r  = (b - a) & 65535;
                mZ = (r == 0);
            end
            3: r = b & a;
            4: r = b | a;
            5: r = b ^ a;
            6: r = a;
            7: begin
                if (sa >= 0) r = (sa >= 16) ? 0 : (b << sa) & 65535;
                else         r = (-sa >= 16) ? 0 : b >> (-sa);
            end
            8: r = md;
            9: r = b;
            default: r = 0;
        endcase
        if (t.op == 0 || t.op == 1 || (t.op >= 3 && t.op <= 8))
            mr[t.rd] = r;
        e_ov  = 1'b1;
        e_res = r;
    endfunction

    always @(negedge clk) begin
        #2;
        if (!reset_n) begin
            model_reset();
            will_acc = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_result", result, 0);
            chk("rst_flags", {C, L, F, Z, N}, 0);
            chk("rst_mem_we", mem_we, 0);
        end else begin
            rdy = !(n == lacc + 1 || n == lacc + 2);
            chk("in_ready", in_ready, rdy);
            chk("out_valid", out_valid, e_ov);
            if (e_ov) chk("result", result, e_res);
            chk("flags", {C, L, F, Z, N}, {mC, mL, mF, mZ, mN});
            chk("mem_we", mem_we, n == sacc + 1);
            if ((n == sacc + 1 || n == lacc + 1) && pend.size() > 0)
                chk("mem_adr", mem_adr, mr[pend[0].rs]);
            if (n == sacc + 1 && pend.size() > 0)
                chk("mem_wdata", mem_wdata, mr[pend[0].rd]);
            e_ov = 1'b0;
            if (pend.size() > 0 && pend[0].due == n)
                exec(pend.pop_front(), int'(mem_data));
            will_acc = in_valid && rdy;
            if (will_acc) begin
                nw.op  = int'(op);
                nw.rd  = int'(rdest);
                nw.rs  = int'(rsrc);
                nw.ui  = use_imm;
                nw.imm = int'(imm) | ((imm_signed && imm[7]) ? 32'hFF00 : 0);
                nw.due = (op == 4'd8) ? n + 2 : n + 1;
                if (op == 4'd8) lacc = n;
                if (op == 4'd9) sacc = n;
                pend.push_back(nw);
            end
        end
        n++;
    end

    task automatic issue(input int o, input int rd, input int rs,
                         input int im, input bit ui, input bit sg);
        bit ok;
        @(negedge clk);
        #1;
        op = 4'(o);
        rdest = 4'(rd);
        rsrc = 4'(rs);
        imm = 8'(im);
        use_imm = ui;
        imm_signed = sg;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            #2;
            if (will_acc) ok = 1'b1;
            else begin
                @(negedge clk);
                #1;
            end
        end
        chk("accept", ok, 1);
    endtask

    task automatic wait_ret(input string nm, input int lat,
                            input logic [15:0] exp);
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        for (int i = 1; i < lat; i++) @(negedge clk);
        #4;
        chk({nm, "_ov"}, out_valid, 1);
        chk(nm, result, exp);
    endtask

    initial begin
        reset_n = 1'b0;
        in_valid = 1'b0;
        op = '0;
        rdest = '0;
        rsrc = '0;
        imm = '0;
        use_imm = 1'b0;
        imm_signed = 1'b0;
        repeat (3) @(negedge clk);
        #1 reset_n = 1'b1;
        #3;
        chk("init_ready", in_ready, 1);
        chk("init_flags", {C, L, F, Z, N}, 0);
        chk("init_result", result, 0);

        issue(6, 1, 0, 5, 1, 0);      wait_ret("mov_r1", 2, 16'd5);
        issue(6, 2, 0, 3, 1, 0);      wait_ret("mov_r2", 2, 16'd3);
        issue(0, 2, 1, 0, 0, 0);      wait_ret("add_5_3", 2, 16'd8);
        chk("add_flags", {C, L, F, Z, N}, 5'b00000);

        issue(6, 1, 0, 1, 1, 0);      wait_ret("mov_1", 2, 16'h0001);
        issue(6, 2, 0, 8'hFF, 1, 1);  wait_ret("mov_ffff", 2, 16'hFFFF);
        issue(2, 2, 1, 0, 0, 0);      wait_ret("cmp", 2, 16'hFFFE);
        chk("cmp_flags", {C, L, F, Z, N}, 5'b00001);
        issue(4, 2, 0, 0, 1, 0);      wait_ret("cmp_nowb", 2, 16'hFFFF);

        issue(6, 4, 0, 8'h80, 1, 0);  wait_ret("mov_80", 2, 16'h0080);
        issue(7, 4, 0, 8, 1, 0);      wait_ret("lsh_8", 2, 16'h8000);
        issue(1, 4, 0, 1, 1, 0);      wait_ret("sub_1", 2, 16'h7FFF);
        issue(0, 4, 0, 1, 1, 0);      wait_ret("add_ovf", 2, 16'h8000);
        chk("ovf_F", F, 1);
        chk("ovf_C", C, 0);
        issue(0, 2, 0, 1, 1, 0);      wait_ret("add_carry", 2, 16'h0000);
        chk("carry_CZ", {C, Z}, 2'b11);

        issue(6, 5, 0, 8'h80, 1, 0);  wait_ret("mov5", 2, 16'h0080);
        issue(7, 5, 0, 8, 1, 0);      wait_ret("lsh5", 2, 16'h8000);
        issue(7, 5, 0, 8'hFC, 1, 1);  wait_ret("lsh_m4", 2, 16'h0800);
        issue(7, 5, 0, 16, 1, 0);     wait_ret("lsh_16", 2, 16'h0000);
        chk("lsh_keep_C", C, 1);

        mem_fix_en = 1'b1;
        mem_fix = 16'hBEEF;
        issue(8, 3, 1, 0, 0, 0);
        issue(0, 3, 3, 0, 0, 0);
        chk("load_ov", out_valid, 1);
        chk("load_val", result, 16'hBEEF);
        wait_ret("ld_add", 2, 16'h7DDE);
        chk("ld_add_CZ", {C, Z}, 2'b10);
        mem_fix_en = 1'b0;

        issue(8, 7, 1, 0, 0, 0);
        @(negedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        #1 reset_n = 1'b0;
        #3;
        chk("abort_ov", out_valid, 0);
        chk("abort_flags", {C, L, F, Z, N}, 0);
        chk("abort_ready", in_ready, 1);
        @(negedge clk);
        #1 reset_n = 1'b1;
        #3 chk("abort_ready_rel", in_ready, 1);
        issue(4, 7, 0, 0, 1, 0);      wait_ret("abort_r7", 2, 16'h0000);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                #1 in_valid = 1'b0;
            end
            if (i == 150) begin
                @(negedge clk);
                #1;
                in_valid = 1'b0;
                reset_n = 1'b0;
                @(negedge clk);
                #1 reset_n = 1'b1;
            end
            issue($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        @(negedge clk);
        #1 in_valid = 1'b0;
        repeat (6) @(negedge clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
